// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter post-processing stages.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package iir_pkg;

    // Fractional bits of the Q1.15 filter coefficients.
    localparam int FRAC_BITS_Q15 = 15;

    // Output holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Clamp a signed value into the range of a signed word of the given width.
    // The result is returned at full width; callers truncate to their own word
    // and detect clipping by comparing against the unclamped input.
    function automatic logic signed [63:0] sat_trunc(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/iir_out_decimator.sv
// Rounds the raw Q.15 filter accumulator, block-averages 2^LOG2_DEC samples and saturates to OUT_WIDTH.
// Latency: result visible two clk edges after the edge that captures the last sample of a block.
// Backpressure: single holding register; an unconsumed result is overwritten by the next one and flagged sticky.
module iir_out_decimator
    import iir_pkg::*;
#(
    parameter int IN_WIDTH  = 30,
    parameter int FRAC_BITS = FRAC_BITS_Q15,
    parameter int LOG2_DEC  = 4,
    parameter int OUT_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic                        din_en,
    input  logic                        clr,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        dout_sat,
    output logic                        ovf_sticky
);

    // Rounded sample keeps one extra bit for the rounding carry; the
    // accumulator adds LOG2_DEC more so a full block can never wrap.
    localparam int S1W  = IN_WIDTH - FRAC_BITS + 1;
    localparam int ACCW = S1W + LOG2_DEC;
    localparam int MW   = ACCW + 1 - LOG2_DEC;

    localparam logic [IN_WIDTH:0]     HALF_LSB = (IN_WIDTH + 1)'(1) << (FRAC_BITS - 1);
    localparam logic [ACCW:0]         HALF_DEC = (ACCW + 1)'(1) << (LOG2_DEC - 1);
    localparam logic [LOG2_DEC-1:0]   CNT_LAST = '1;

    logic signed [S1W-1:0]       s1;
    logic                        s1_v;
    logic signed [S1W-1:0]       s1_nxt;
    logic signed [ACCW-1:0]      acc;
    logic [LOG2_DEC-1:0]         cnt;
    logic signed [ACCW-1:0]      sum;
    logic signed [MW-1:0]        mean;
    logic signed [OUT_WIDTH-1:0] sat_dat;
    logic                        sat_flag;
    logic signed [OUT_WIDTH-1:0] res_dat;
    logic                        res_sat;
    logic                        res_v;
    out_state_t                  state;

    // Round half up: add half an LSB in one extra bit, then drop the fraction.
    assign s1_nxt = S1W'(({din[IN_WIDTH-1], din} + HALF_LSB) >> FRAC_BITS);

    // Block sum including the sample currently in stage 1, and its rounded mean.
    assign sum  = acc + ACCW'(s1);
    assign mean = $signed(MW'(({sum[ACCW-1], sum} + HALF_DEC) >> LOG2_DEC));

    assign sat_dat  = OUT_WIDTH'(sat_trunc(64'(mean), OUT_WIDTH));
    assign sat_flag = (sat_trunc(64'(mean), OUT_WIDTH) != 64'(mean));

    assign dout_valid = (state == FULL);

    // Stage 1: capture and round each accepted sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1   <= '0;
            s1_v <= 1'b0;
        end else if (clr) begin
            s1_v <= 1'b0;
        end else begin
            s1_v <= din_en;
            if (din_en) begin
                s1 <= s1_nxt;
            end
        end
    end

    // Stage 2: accumulate a block of samples; emit its saturated mean on the last one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc     <= '0;
            cnt     <= '0;
            res_dat <= '0;
            res_sat <= 1'b0;
            res_v   <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            cnt   <= '0;
            res_v <= 1'b0;
        end else begin
            res_v <= 1'b0;
            if (s1_v) begin
                if (cnt == CNT_LAST) begin
                    acc     <= '0;
                    cnt     <= '0;
                    res_dat <= sat_dat;
                    res_sat <= sat_flag;
                    res_v   <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + LOG2_DEC'(1);
                end
            end
        end
    end

    // Output holding register: newest result always wins, a lost result sets the sticky flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= EMPTY;
            dout       <= '0;
            dout_sat   <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            state      <= EMPTY;
            dout_sat   <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (res_v) begin
                        dout     <= res_dat;
                        dout_sat <= res_sat;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (res_v) begin
                        dout     <= res_dat;
                        dout_sat <= res_sat;
                        if (!dout_ready) begin
                            ovf_sticky <= 1'b1;
                        end
                    end else if (dout_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_out_decimator.sv
// Directed self-checking bench for iir_out_decimator with default parameters.
// Latency: checks the two-edge result latency and one-cycle valid with ready high.
// Backpressure: exercises overwrite, sticky overflow and same-cycle accept.
module tb_iir_out_decimator;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [29:0] din;
    logic        din_en;
    logic        clr;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_sat;
    logic        ovf_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    iir_out_decimator dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .din        (din),
        .din_en     (din_en),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_sat   (dout_sat),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input int n);
        din    = 30'(v);
        din_en = 1'b1;
        repeat (n) step();
        din_en = 1'b0;
    endtask

    task automatic idle(input int n);
        din_en = 1'b0;
        repeat (n) step();
    endtask

    task automatic flush();
        clr    = 1'b1;
        din_en = 1'b0;
        step();
        clr        = 1'b0;
        dout_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        n_rst      = 1'b0;
        din        = '0;
        din_en     = 1'b0;
        clr        = 1'b0;
        dout_ready = 1'b1;
        idle(3);
        n_tests++;
        if (dout !== 12'h000) begin
            n_fail++; $display("FAIL reset_dout: got %0d expected 0", $signed(dout));
        end
        n_tests++;
        if ({dout_valid, dout_sat, ovf_sticky} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got v/s/o=%b expected 000", {dout_valid, dout_sat, ovf_sticky});
        end
        n_rst = 1'b1;
        idle(2);
    endtask

    task automatic test_constant();
        int nv;
        int first_at;
        int second_at;
        nv = 0; first_at = -1; second_at = -1;
        dout_ready = 1'b1;
        din = 30'(3276800);
        for (int cyc = 1; cyc <= 36; cyc++) begin
            din_en = (cyc <= 32);
            step();
            if (dout_valid === 1'b1) begin
                nv++;
                if (first_at < 0) first_at = cyc; else if (second_at < 0) second_at = cyc;
                n_tests++;
                if (dout !== 12'd100 || dout_sat !== 1'b0) begin
                    n_fail++; $display("FAIL const_value: got dout=%0d sat=%b expected 100 sat=0", $signed(dout), dout_sat);
                end
            end
        end
        n_tests++;
        if (nv != 2) begin
            n_fail++; $display("FAIL const_count: got %0d valid cycles expected 2", nv);
        end
        n_tests++;
        if (first_at != 18 || second_at != 34) begin
            n_fail++; $display("FAIL const_timing: got edges %0d,%0d expected 18,34", first_at, second_at);
        end
        idle(2);
    endtask

    task automatic test_rounding();
        dout_ready = 1'b1;
        feed(16384, 16);
        idle(2);
        n_tests++;
        if ({dout_valid, dout} !== {1'b1, 12'd1}) begin
            n_fail++; $display("FAIL round_half_pos: got v=%b dout=%0d expected v=1 dout=1", dout_valid, $signed(dout));
        end
        idle(2);
        feed(-16384, 16);
        idle(2);
        n_tests++;
        if ({dout_valid, dout} !== {1'b1, 12'd0}) begin
            n_fail++; $display("FAIL round_half_neg: got v=%b dout=%0d expected v=1 dout=0", dout_valid, $signed(dout));
        end
        idle(2);
        for (int i = 0; i < 16; i++) begin
            din    = (i % 2 == 0) ? 30'd32768 : 30'd0;
            din_en = 1'b1;
            step();
        end
        idle(2);
        n_tests++;
        if ({dout_valid, dout} !== {1'b1, 12'd1}) begin
            n_fail++; $display("FAIL round_mean_half: got v=%b dout=%0d expected v=1 dout=1", dout_valid, $signed(dout));
        end
        idle(2);
    endtask

    task automatic test_saturation();
        dout_ready = 1'b1;
        feed(98304000, 16);
        idle(2);
        n_tests++;
        if ({dout_valid, dout_sat, dout} !== {1'b1, 1'b1, 12'h7FF}) begin
            n_fail++; $display("FAIL sat_pos: got v=%b sat=%b dout=%0d expected v=1 sat=1 dout=2047", dout_valid, dout_sat, $signed(dout));
        end
        idle(2);
        feed(-98304000, 16);
        idle(2);
        n_tests++;
        if ({dout_valid, dout_sat, dout} !== {1'b1, 1'b1, 12'h800}) begin
            n_fail++; $display("FAIL sat_neg: got v=%b sat=%b dout=%0d expected v=1 sat=1 dout=-2048", dout_valid, dout_sat, $signed(dout));
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b0;
        feed(163840, 16);
        feed(229376, 16);
        idle(2);
        n_tests++;
        if ({dout_valid, dout, ovf_sticky} !== {1'b1, 12'd7, 1'b1}) begin
            n_fail++; $display("FAIL bp_overwrite: got v=%b dout=%0d ovf=%b expected v=1 dout=7 ovf=1", dout_valid, $signed(dout), ovf_sticky);
        end
        dout_ready = 1'b1;
        step();
        n_tests++;
        if ({dout_valid, dout, ovf_sticky} !== {1'b0, 12'd7, 1'b1}) begin
            n_fail++; $display("FAIL bp_consume: got v=%b dout=%0d ovf=%b expected v=0 dout=7 ovf=1", dout_valid, $signed(dout), ovf_sticky);
        end
        idle(2);
    endtask

    task automatic test_clear();
        bit seen;
        dout_ready = 1'b1;
        feed(1638400, 8);
        clr    = 1'b1;
        din_en = 1'b1;
        step();
        clr    = 1'b0;
        din_en = 1'b0;
        n_tests++;
        if ({dout_valid, ovf_sticky, dout_sat} !== 3'b000) begin
            n_fail++; $display("FAIL clr_flags: got v/o/s=%b expected 000", {dout_valid, ovf_sticky, dout_sat});
        end
        seen = 1'b0;
        din  = 30'(98304);
        for (int i = 0; i < 17; i++) begin
            din_en = (i < 15);
            step();
            if (dout_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL clr_early_result: got valid after 15 samples expected none");
        end
        feed(98304, 1);
        idle(2);
        n_tests++;
        if ({dout_valid, dout} !== {1'b1, 12'd3}) begin
            n_fail++; $display("FAIL clr_result: got v=%b dout=%0d expected v=1 dout=3", dout_valid, $signed(dout));
        end
        idle(2);
    endtask

    task automatic test_same_cycle();
        flush();
        dout_ready = 1'b0;
        feed(65536, 16);
        feed(294912, 16);
        idle(1);
        dout_ready = 1'b1;
        step();
        n_tests++;
        if ({dout_valid, dout, ovf_sticky} !== {1'b1, 12'd9, 1'b0}) begin
            n_fail++; $display("FAIL same_cycle_accept: got v=%b dout=%0d ovf=%b expected v=1 dout=9 ovf=0", dout_valid, $signed(dout), ovf_sticky);
        end
        step();
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_drain: got v=%b expected 0", dout_valid);
        end
        idle(2);
    endtask

    task automatic test_gaps();
        int first_at;
        logic [11:0] got;
        first_at = -1;
        got = '0;
        dout_ready = 1'b1;
        din = 30'(3276800);
        for (int cyc = 1; cyc <= 34; cyc++) begin
            din_en = (cyc <= 32) && (cyc % 2 == 1);
            step();
            if (dout_valid === 1'b1 && first_at < 0) begin
                first_at = cyc;
                got = dout;
            end
        end
        din_en = 1'b0;
        n_tests++;
        if (first_at != 33 || got !== 12'd100) begin
            n_fail++; $display("FAIL gaps: got edge %0d dout=%0d expected edge 33 dout=100", first_at, $signed(got));
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        bit seen;
        dout_ready = 1'b1;
        feed(3276800, 8);
        n_rst = 1'b0;
        #1;
        n_tests++;
        if ({dout, dout_valid, dout_sat, ovf_sticky} !== 15'd0) begin
            n_fail++; $display("FAIL rst_mid_block: got dout=%0d v/s/o=%b expected all 0", $signed(dout), {dout_valid, dout_sat, ovf_sticky});
        end
        step();
        n_rst = 1'b1;
        seen  = 1'b0;
        din   = 30'(3276800);
        for (int i = 0; i < 17; i++) begin
            din_en = (i < 15);
            step();
            if (dout_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rst_partial_kept: got valid after 15 samples expected none");
        end
        feed(3276800, 1);
        idle(2);
        n_tests++;
        if ({dout_valid, dout} !== {1'b1, 12'd100}) begin
            n_fail++; $display("FAIL rst_first_result: got v=%b dout=%0d expected v=1 dout=100", dout_valid, $signed(dout));
        end
        idle(2);
        dout_ready = 1'b0;
        feed(3276800, 16);
        idle(2);
        n_tests++;
        if (dout_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_full_setup: got v=%b expected 1", dout_valid);
        end
        #1;
        n_rst = 1'b0;
        #1;
        n_tests++;
        if ({dout, dout_valid, dout_sat, ovf_sticky} !== 15'd0) begin
            n_fail++; $display("FAIL rst_mid_full: got dout=%0d v/s/o=%b expected all 0", $signed(dout), {dout_valid, dout_sat, ovf_sticky});
        end
        step();
        n_rst = 1'b1;
        dout_ready = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_clear();
        test_same_cycle();
        test_gaps();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
